logic_axi4_lite_write_arbiter: RTL and testbench
================================================

// Module: logic_axi4_lite_write_arbiter
//
// PURPOSE
//  Shares one AXI4-Lite write path (AW, W, B) between SLAVES requesters.
//  Each grant carries one complete write: the AW and W beats of the same requester, then its B response.
//  Sits in front of the write-alignment stage, so downstream sees paired AW/W from a single source.
//  The read channels do not pass through this block.
//
// PARAMETERS
//  SLAVES         2  number of requesting ports, >= 2
//  DATA_BYTES     4  write data width in bytes; data = 8*DATA_BYTES bits
//  ADDRESS_WIDTH  1  AW address width in bits
//
// PORTS
//  aclk           in   1                  clock
//  areset         in   1                  asynchronous reset, active-high
//  slave_aw*      in   [SLAVES][..]       awvalid, awaddr, awprot per requester
//  slave_awready  out  [SLAVES]           AW accepted, granted requester only
//  slave_w*       in   [SLAVES][..]       wvalid, wdata, wstrb per requester
//  slave_wready   out  [SLAVES]           W accepted, granted requester only
//  slave_bvalid   out  [SLAVES]           B response valid, granted requester only
//  slave_bresp    out  [SLAVES][2]        B response code
//  slave_bready   in   [SLAVES]           requester accepts B
//  master_aw*     out  awvalid, awaddr[ADDRESS_WIDTH], awprot[3];  master_awready in 1
//  master_w*      out  wvalid, wdata[8*DATA_BYTES], wstrb[DATA_BYTES];  master_wready in 1
//  master_b*      in   bvalid 1, bresp 2;  master_bready out 1
//
// BEHAVIOUR
//  - Reset: state IDLE; grant index 0; rr pointer 0; aw_done and w_done 0.
//    All valid and ready outputs are 0 while areset is high and in the first cycle after release.
//  - Request: requester i requests when slave_awvalid[i] && slave_wvalid[i].
//    A lone AW or a lone W never wins.
//  - IDLE: if any request is present, register the winner into grant and go to XFER (1 cycle).
//    No request: stay in IDLE.
//  - XFER: AW and W are forwarded combinationally from the grant index.
//    - master_awvalid = slave_awvalid[g] & ~aw_done; slave_awready[g] = master_awready & ~aw_done.
//    - W channel follows the same rule with w_done.
//    - aw_done and w_done set on their own handshakes, in either order or in the same cycle.
//    - When both handshakes are done (including same cycle), clear aw_done and w_done and go to RESP.
//  - RESP: master_bready = slave_bready[g]; slave_bvalid[g] = master_bvalid; bresp passes through.
//    On the B handshake, rr pointer = g+1 (wraps SLAVES-1 -> 0) and state goes to IDLE.
//  - Ungranted ports: awready, wready and bvalid are 0.
//    slave_bresp is 2'b00 on every port except the granted one in RESP.
//  - Latency: request at cycle 0 -> master_awvalid/master_wvalid high at cycle 1.
//    Back-to-back grants have 1 IDLE cycle between a B handshake and the next XFER.
//  - Round-robin: search starts at the rr pointer and wraps modulo SLAVES.
//    With all ports requesting, grants go 0,1,..,SLAVES-1,0.
//  - The grant never changes before the B handshake, even if the requester drops valid (protocol violation).
//  - One outstanding write at a time.
//  - Width rules: grant index is $clog2(SLAVES) bits; rr increment wraps explicitly, not by overflow,
//    so non-power-of-two SLAVES is valid.
//  - Reset mid-operation: all state returns to the reset values immediately.
//    The in-flight AW, W or B is abandoned and is not replayed.
//
// CONFIGURATION
//  LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN
//   - Defined: fixed priority; the lowest requesting index wins and the rr pointer is unused (held 0).
//   - Undefined (default): round-robin as in BEHAVIOUR.
//
// STRUCTURE
//  - Package logic_axi4_lite_write_arbiter_pkg:
//    state enum {IDLE, XFER, RESP}; response constants OKAY=2'b00, SLVERR=2'b10.
//  - Sub-module logic_axi4_lite_write_arbiter_grant:
//    combinational requests[SLAVES] + pointer -> winner index + any.
//    It holds both the round-robin and the fixed-priority logic under the macro.
//  - Top level: state register, done flags, grant/pointer registers, channel muxing.
//
// TESTING
//  1. Only port 1 requests, awaddr=0x4, wdata=0xA5A5A5A5, awready=wready=1, bresp=OKAY
//     -> master AW/W valid at cycle 1; slave_bvalid[1] with OKAY; ports 0 and 2 never see ready or bvalid.
//  2. All 3 ports request continuously for 6 writes -> grant order 0,1,2,0,1,2.
//     With PRIORITY_EN -> 0,0,0,... while port 0 keeps requesting.
//  3. master_awready=1 at cycle 1, master_wready held 0 until cycle 4
//     -> awvalid drops after cycle 1; wvalid held to cycle 4; RESP entered at cycle 5.
//  4. Port 0 asserts AW only, port 1 asserts AW+W -> port 1 is granted; port 0 waits until its W arrives.
//  5. master_bvalid held with bresp=SLVERR while slave_bready[2]=0 for 3 cycles
//     -> slave_bvalid[2] held with SLVERR, no new grant until slave_bready[2]=1.
//  6. areset pulsed during XFER after the AW handshake
//     -> all outputs 0 next cycle; the same request is re-granted from port 0 with a fresh AW.

Source files
------------

// File: rtl/logic_axi4_lite_write_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite write arbiter.
package logic_axi4_lite_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/logic_axi4_lite_write_arbiter_grant.sv
// Combinational winner selection for the write arbiter.
// LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN selects fixed priority (lowest index wins);
// otherwise a round-robin search starts at pointer_i and wraps modulo SLAVES.
module logic_axi4_lite_write_arbiter_grant #(
  parameter int unsigned SLAVES = 2,
  localparam int unsigned IdxW  = $clog2(SLAVES)
) (
  input  logic [SLAVES-1:0] requests_i,
  input  logic [IdxW-1:0]   pointer_i,
  output logic [IdxW-1:0]   winner_o,
  output logic              any_o
);

  assign any_o = |requests_i;

`ifdef LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN
  // Pointer is meaningless in fixed-priority mode.
  logic unused_pointer;
  assign unused_pointer = ^pointer_i;

  // Scan from the top down so the lowest requesting index is the last assignment.
  always_comb begin
    winner_o = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (requests_i[i]) winner_o = IdxW'(i);
    end
  end
`else
  // First requester at or after the pointer, wrapping explicitly for non-power-of-two counts.
  always_comb begin
    logic found;
    int unsigned idx;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < SLAVES; k++) begin
      idx = int'(pointer_i) + k;
      if (idx >= SLAVES) idx = idx - SLAVES;
      if (!found && requests_i[idx]) begin
        winner_o = IdxW'(idx);
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/logic_axi4_lite_write_arbiter.sv
// AXI4-Lite write arbiter: one complete AW+W+B transaction per grant, one outstanding write.
// Optional macro LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN switches round-robin to fixed priority.
module logic_axi4_lite_write_arbiter
  import logic_axi4_lite_write_arbiter_pkg::*;
#(
  parameter int unsigned SLAVES        = 2,
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned ADDRESS_WIDTH = 1
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [SLAVES-1:0]                       slave_awvalid,
  input  logic [SLAVES-1:0][ADDRESS_WIDTH-1:0]    slave_awaddr,
  input  logic [SLAVES-1:0][2:0]                  slave_awprot,
  output logic [SLAVES-1:0]                       slave_awready,
  input  logic [SLAVES-1:0]                       slave_wvalid,
  input  logic [SLAVES-1:0][8*DATA_BYTES-1:0]     slave_wdata,
  input  logic [SLAVES-1:0][DATA_BYTES-1:0]       slave_wstrb,
  output logic [SLAVES-1:0]                       slave_wready,
  output logic [SLAVES-1:0]                       slave_bvalid,
  output logic [SLAVES-1:0][1:0]                  slave_bresp,
  input  logic [SLAVES-1:0]                       slave_bready,
  output logic                                    master_awvalid,
  output logic [ADDRESS_WIDTH-1:0]                master_awaddr,
  output logic [2:0]                              master_awprot,
  input  logic                                    master_awready,
  output logic                                    master_wvalid,
  output logic [8*DATA_BYTES-1:0]                 master_wdata,
  output logic [DATA_BYTES-1:0]                   master_wstrb,
  input  logic                                    master_wready,
  input  logic                                    master_bvalid,
  input  logic [1:0]                              master_bresp,
  output logic                                    master_bready
);

  localparam int unsigned IdxW = $clog2(SLAVES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SLAVES - 1);

  state_e            state_q;
  logic [IdxW-1:0]   grant_q;
  logic [IdxW-1:0]   rr_q;
  logic              aw_done_q;
  logic              w_done_q;

  logic [SLAVES-1:0] requests;
  logic [IdxW-1:0]   winner;
  logic              any_req;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;

  // A port only competes once both its AW and W are presented.
  assign requests = slave_awvalid & slave_wvalid;

  logic_axi4_lite_write_arbiter_grant #(
    .SLAVES (SLAVES)
  ) u_grant (
    .requests_i (requests),
    .pointer_i  (rr_q),
    .winner_o   (winner),
    .any_o      (any_req)
  );

  assign aw_hs = master_awvalid & master_awready;
  assign w_hs  = master_wvalid & master_wready;
  assign b_hs  = master_bvalid & master_bready;

  // Arbitration FSM: grant, done flags and round-robin pointer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= XFER;
          end
        end
        XFER: begin
          // AW and W may complete in either order or together.
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= RESP;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        end
        RESP: begin
          if (b_hs) begin
`ifdef LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN
            rr_q <= '0;
`else
            rr_q <= (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
`endif
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Channel muxing from the granted port; everything else idles at zero.
  always_comb begin
    master_awvalid = 1'b0;
    master_awaddr  = '0;
    master_awprot  = '0;
    master_wvalid  = 1'b0;
    master_wdata   = '0;
    master_wstrb   = '0;
    master_bready  = 1'b0;
    slave_awready  = '0;
    slave_wready   = '0;
    slave_bvalid   = '0;
    for (int unsigned i = 0; i < SLAVES; i++) slave_bresp[i] = OKAY;
    unique case (state_q)
      XFER: begin
        master_awvalid         = slave_awvalid[grant_q] & ~aw_done_q;
        master_awaddr          = slave_awaddr[grant_q];
        master_awprot          = slave_awprot[grant_q];
        slave_awready[grant_q] = master_awready & ~aw_done_q;
        master_wvalid          = slave_wvalid[grant_q] & ~w_done_q;
        master_wdata           = slave_wdata[grant_q];
        master_wstrb           = slave_wstrb[grant_q];
        slave_wready[grant_q]  = master_wready & ~w_done_q;
      end
      RESP: begin
        master_bready         = slave_bready[grant_q];
        slave_bvalid[grant_q] = master_bvalid;
        slave_bresp[grant_q]  = master_bresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_logic_axi4_lite_write_arbiter.sv
// Directed self-checking bench for logic_axi4_lite_write_arbiter with three requesters.
module tb_logic_axi4_lite_write_arbiter;

  localparam int unsigned SLAVES        = 3;
  localparam int unsigned DATA_BYTES    = 4;
  localparam int unsigned ADDRESS_WIDTH = 8;

  logic                      aclk;
  logic                      areset;
  logic [2:0]                slave_awvalid;
  logic [2:0][7:0]           slave_awaddr;
  logic [2:0][2:0]           slave_awprot;
  logic [2:0]                slave_awready;
  logic [2:0]                slave_wvalid;
  logic [2:0][31:0]          slave_wdata;
  logic [2:0][3:0]           slave_wstrb;
  logic [2:0]                slave_wready;
  logic [2:0]                slave_bvalid;
  logic [2:0][1:0]           slave_bresp;
  logic [2:0]                slave_bready;
  logic                      master_awvalid;
  logic [7:0]                master_awaddr;
  logic [2:0]                master_awprot;
  logic                      master_awready;
  logic                      master_wvalid;
  logic [31:0]               master_wdata;
  logic [3:0]                master_wstrb;
  logic                      master_wready;
  logic                      master_bvalid;
  logic [1:0]                master_bresp;
  logic                      master_bready;

  int checks;
  int failures;

  logic_axi4_lite_write_arbiter #(
    .SLAVES        (SLAVES),
    .DATA_BYTES    (DATA_BYTES),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .slave_awvalid  (slave_awvalid),
    .slave_awaddr   (slave_awaddr),
    .slave_awprot   (slave_awprot),
    .slave_awready  (slave_awready),
    .slave_wvalid   (slave_wvalid),
    .slave_wdata    (slave_wdata),
    .slave_wstrb    (slave_wstrb),
    .slave_wready   (slave_wready),
    .slave_bvalid   (slave_bvalid),
    .slave_bresp    (slave_bresp),
    .slave_bready   (slave_bready),
    .master_awvalid (master_awvalid),
    .master_awaddr  (master_awaddr),
    .master_awprot  (master_awprot),
    .master_awready (master_awready),
    .master_wvalid  (master_wvalid),
    .master_wdata   (master_wdata),
    .master_wstrb   (master_wstrb),
    .master_wready  (master_wready),
    .master_bvalid  (master_bvalid),
    .master_bresp   (master_bresp),
    .master_bready  (master_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // All valid/ready outputs packed together.
  function automatic logic [11:0] outs();
    return {master_awvalid, master_wvalid, master_bready,
            slave_awready, slave_wready, slave_bvalid};
  endfunction

  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_g;
    checks   = 0;
    failures = 0;
    areset         = 1'b1;
    slave_awvalid  = '0;
    slave_awaddr   = '0;
    slave_awprot   = '0;
    slave_wvalid   = '0;
    slave_wdata    = '0;
    slave_wstrb    = '0;
    slave_bready   = '0;
    master_awready = 1'b0;
    master_wready  = 1'b0;
    master_bvalid  = 1'b0;
    master_bresp   = 2'b00;

    // Reset state.
    smp();
    chk("reset_outputs", 64'(outs()), 64'h0);
    nxt();
    areset = 1'b0;

    // Test 1: only port 1 requests.
    slave_awvalid   = 3'b010;
    slave_wvalid    = 3'b010;
    slave_awaddr[1] = 8'h04;
    slave_wdata[1]  = 32'hA5A5_A5A5;
    slave_wstrb[1]  = 4'hF;
    master_awready  = 1'b1;
    master_wready   = 1'b1;
    slave_bready    = 3'b111;
    smp();
    chk("t1_cycle0_outputs", 64'(outs()), 64'h0);
    nxt();
    smp();
    chk("t1_awvalid", 64'(master_awvalid), 64'h1);
    chk("t1_wvalid", 64'(master_wvalid), 64'h1);
    chk("t1_awaddr", 64'(master_awaddr), 64'h04);
    chk("t1_wdata", 64'(master_wdata), 64'hA5A5_A5A5);
    chk("t1_slave_awready", 64'(slave_awready), 64'h2);
    chk("t1_slave_wready", 64'(slave_wready), 64'h2);
    nxt();
    slave_awvalid = '0;
    slave_wvalid  = '0;
    master_bvalid = 1'b1;
    master_bresp  = 2'b00;
    smp();
    chk("t1_slave_bvalid", 64'(slave_bvalid), 64'h2);
    chk("t1_master_bready", 64'(master_bready), 64'h1);
    chk("t1_slave_bresp", 64'(slave_bresp), 64'h0);
    chk("t1_no_ready_in_resp", 64'({slave_awready, slave_wready}), 64'h0);
    nxt();
    master_bvalid = 1'b0;
    smp();
    chk("t1_idle_after_b", 64'(outs()), 64'h0);
    nxt();

    // Test 2: all ports request continuously after a reset; six writes.
    slave_awvalid   = 3'b111;
    slave_wvalid    = 3'b111;
    slave_awaddr[0] = 8'h10;
    slave_awaddr[1] = 8'h11;
    slave_awaddr[2] = 8'h12;
    master_bvalid   = 1'b1;
    areset          = 1'b1;
    smp();
    chk("t2_outputs_in_reset", 64'(outs()), 64'h0);
    nxt();
    areset = 1'b0;
    for (int n = 0; n < 6; n++) begin
`ifdef LOGIC_AXI4_LITE_WRITE_ARBITER_PRIORITY_EN
      exp_g = 3'b001;
`else
      exp_g = 3'(1 << (n % 3));
`endif
      smp();
      chk($sformatf("t2_idle_gap_%0d", n), 64'(master_awvalid), 64'h0);
      nxt();
      smp();
      chk($sformatf("t2_grant_%0d", n), 64'(slave_awready), 64'(exp_g));
      chk($sformatf("t2_awaddr_%0d", n), 64'(master_awaddr),
          64'(exp_g == 3'b001 ? 8'h10 : (exp_g == 3'b010 ? 8'h11 : 8'h12)));
      nxt();
      smp();
      chk($sformatf("t2_bvalid_%0d", n), 64'(slave_bvalid), 64'(exp_g));
      nxt();
    end
    slave_awvalid = '0;
    slave_wvalid  = '0;
    master_bvalid = 1'b0;

    // Test 3: AW accepted at cycle 1, W stalled until cycle 4.
    slave_awvalid   = 3'b001;
    slave_wvalid    = 3'b001;
    slave_awaddr[0] = 8'h20;
    master_awready  = 1'b1;
    master_wready   = 1'b0;
    smp();
    chk("t3_cycle0_awvalid", 64'(master_awvalid), 64'h0);
    nxt();
    smp();
    chk("t3_cycle1_aw_w_valid", 64'({master_awvalid, master_wvalid}), 64'h3);
    chk("t3_cycle1_awready", 64'(slave_awready), 64'h1);
    nxt();
    smp();
    chk("t3_cycle2_aw_dropped", 64'({master_awvalid, master_wvalid}), 64'h1);
    chk("t3_cycle2_readies", 64'({slave_awready, slave_wready}), 64'h0);
    nxt();
    smp();
    chk("t3_cycle3_w_held", 64'({master_awvalid, master_wvalid}), 64'h1);
    nxt();
    master_wready = 1'b1;
    smp();
    chk("t3_cycle4_wready", 64'(slave_wready), 64'h1);
    chk("t3_cycle4_no_bvalid", 64'(slave_bvalid), 64'h0);
    nxt();
    slave_awvalid = '0;
    slave_wvalid  = '0;
    master_bvalid = 1'b1;
    smp();
    chk("t3_cycle5_resp", 64'(slave_bvalid), 64'h1);
    chk("t3_cycle5_bready", 64'(master_bready), 64'h1);
    nxt();
    master_bvalid = 1'b0;

    // Test 4: port 0 lone AW, port 1 AW+W.
    slave_awvalid   = 3'b011;
    slave_wvalid    = 3'b010;
    slave_awaddr[1] = 8'h30;
    master_bvalid   = 1'b1;
    smp();
    nxt();
    smp();
    chk("t4_port1_granted", 64'(slave_awready), 64'h2);
    chk("t4_awaddr", 64'(master_awaddr), 64'h30);
    nxt();
    slave_awvalid = 3'b001;
    slave_wvalid  = 3'b000;
    smp();
    chk("t4_port1_bvalid", 64'(slave_bvalid), 64'h2);
    nxt();
    smp();
    chk("t4_lone_aw_wait_a", 64'({master_awvalid, slave_awready}), 64'h0);
    nxt();
    smp();
    chk("t4_lone_aw_wait_b", 64'({master_awvalid, slave_awready}), 64'h0);
    nxt();
    slave_wvalid = 3'b001;
    smp();
    chk("t4_w_arrives_idle", 64'(master_awvalid), 64'h0);
    nxt();
    smp();
    chk("t4_port0_granted", 64'(slave_awready), 64'h1);
    chk("t4_port0_awaddr", 64'(master_awaddr), 64'h20);
    nxt();
    slave_awvalid = '0;
    slave_wvalid  = '0;
    smp();
    chk("t4_port0_bvalid", 64'(slave_bvalid), 64'h1);
    nxt();
    master_bvalid = 1'b0;

    // Test 5: SLVERR held on port 2 while its bready is low.
    slave_awvalid   = 3'b100;
    slave_wvalid    = 3'b100;
    slave_awaddr[2] = 8'h40;
    smp();
    nxt();
    smp();
    chk("t5_port2_granted", 64'(slave_awready), 64'h4);
    nxt();
    slave_awvalid = 3'b001;
    slave_wvalid  = 3'b001;
    master_bvalid = 1'b1;
    master_bresp  = 2'b10;
    slave_bready  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("t5_bvalid_held_%0d", k), 64'(slave_bvalid), 64'h4);
      chk($sformatf("t5_bresp_held_%0d", k), 64'(slave_bresp), 64'h20);
      chk($sformatf("t5_no_new_grant_%0d", k),
          64'({master_bready, master_awvalid, slave_awready}), 64'h0);
      nxt();
    end
    slave_bready = 3'b100;
    smp();
    chk("t5_bvalid_release", 64'(slave_bvalid), 64'h4);
    chk("t5_bready_release", 64'(master_bready), 64'h1);
    nxt();
    master_bresp = 2'b00;
    slave_bready = 3'b111;
    smp();
    chk("t5_idle_gap", 64'(master_awvalid), 64'h0);
    nxt();
    smp();
    chk("t5_port0_granted", 64'(slave_awready), 64'h1);
    nxt();
    slave_awvalid = '0;
    slave_wvalid  = '0;
    smp();
    chk("t5_port0_bvalid", 64'(slave_bvalid), 64'h1);
    chk("t5_port0_bresp", 64'(slave_bresp), 64'h0);
    nxt();
    master_bvalid = 1'b0;

    // Test 6: reset during XFER after the AW handshake.
    slave_awvalid   = 3'b010;
    slave_wvalid    = 3'b010;
    slave_awaddr[1] = 8'h50;
    master_awready  = 1'b1;
    master_wready   = 1'b0;
    smp();
    nxt();
    smp();
    chk("t6_aw_handshake", 64'({master_awvalid, slave_awready}), 64'hA);
    nxt();
    smp();
    chk("t6_aw_done", 64'({master_awvalid, master_wvalid}), 64'h1);
    #1;
    areset = 1'b1;
    #1;
    chk("t6_outputs_in_reset", 64'(outs()), 64'h0);
    nxt();
    areset = 1'b0;
    smp();
    chk("t6_first_after_release", 64'(outs()), 64'h0);
    nxt();
    master_wready = 1'b1;
    smp();
    chk("t6_fresh_awvalid", 64'(master_awvalid), 64'h1);
    chk("t6_regrant", 64'(slave_awready), 64'h2);
    chk("t6_awaddr", 64'(master_awaddr), 64'h50);
    nxt();
    slave_awvalid = '0;
    slave_wvalid  = '0;
    master_bvalid = 1'b1;
    smp();
    chk("t6_bvalid", 64'(slave_bvalid), 64'h2);
    nxt();
    master_bvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
